// File: rtl/csi_video_pkg.sv
// Shared definitions for the CSI video path: stream FSM encoding and default widths.
package csi_video_pkg;

   localparam int COORD_WIDTH_DEF = 12;
   localparam int DATA_WIDTH_DEF  = 32;

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      IN_LINE  = 2'd1,
      LINE_GAP = 2'd2
   } vid_state_t;

endpackage

// File: rtl/video_timing_counter.sv
// Frame/line timing tracker: sync edge detection, saturating x/y position of the
// current word, frame geometry measurement and line-length consistency check.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   WAIT_SOF | idle between frames, waiting for a frame_sync rising edge
//   IN_LINE  | inside a frame, receiving words of a line
//   LINE_GAP | inside a frame, between lines (line_sync low)
module video_timing_counter
   import csi_video_pkg::*;
#(
   parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   frame_sync_i,
   input  logic                   line_sync_i,
   input  logic                   clear_err_i,
   output logic                   word_valid,
   output logic                   sof_strobe,
   output logic                   eof_strobe,
   output logic [COORD_WIDTH-1:0] x,
   output logic [COORD_WIDTH-1:0] y,
   output logic [COORD_WIDTH-1:0] frame_width,
   output logic [COORD_WIDTH-1:0] frame_height,
   output logic                   geometry_valid,
   output logic                   line_len_err
);

   localparam logic [COORD_WIDTH-1:0] C_MAX = '1;
   localparam logic [COORD_WIDTH-1:0] C_ONE = COORD_WIDTH'(1);

   function automatic logic [COORD_WIDTH-1:0] sat_inc(input logic [COORD_WIDTH-1:0] v);
      return (v == C_MAX) ? v : v + C_ONE;
   endfunction

   vid_state_t             state, state_next;
   logic                   fs_d;
   logic [COORD_WIDTH-1:0] x_cnt, y_cnt, ref_len;
   logic                   fs_rise, fs_fall, in_frame;
   logic                   line_open, line_close, len_mismatch;
   logic [COORD_WIDTH-1:0] close_len;

   assign fs_rise    = frame_sync_i & ~fs_d;
   assign fs_fall    = ~frame_sync_i & fs_d;
   assign in_frame   = (state != WAIT_SOF);
   assign sof_strobe = (state == WAIT_SOF) & fs_rise;
   assign eof_strobe = in_frame & fs_fall;
   assign word_valid = line_sync_i & (sof_strobe | in_frame);
   assign x          = sof_strobe ? '0 : x_cnt;
   assign y          = sof_strobe ? '0 : y_cnt;

   // A line still open when frame_sync falls (or whose last word arrives on that
   // very cycle) is closed by the EOF edge, so it counts toward height and length.
   assign line_open    = (state == IN_LINE) | line_sync_i;
   assign line_close   = in_frame & (fs_fall ? line_open : ((state == IN_LINE) & ~line_sync_i));
   assign close_len    = line_sync_i ? sat_inc(x_cnt) : x_cnt;
   assign len_mismatch = line_close & (y_cnt != '0) & (close_len != ref_len);

   // Sync delay flop resets high so a frame already in progress at reset
   // release is not mistaken for a new SOF.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= WAIT_SOF;
         fs_d  <= 1'b1;
      end else begin
         state <= state_next;
         fs_d  <= frame_sync_i;
      end
   end

   // Next-state decode; frame_sync fall takes priority over line transitions.
   always_comb begin
      state_next = state;
      case (state)
         WAIT_SOF: if (fs_rise) state_next = line_sync_i ? IN_LINE : LINE_GAP;
         IN_LINE: begin
            if (fs_fall)           state_next = WAIT_SOF;
            else if (!line_sync_i) state_next = LINE_GAP;
         end
         LINE_GAP: begin
            if (fs_fall)          state_next = WAIT_SOF;
            else if (line_sync_i) state_next = IN_LINE;
         end
         default: state_next = WAIT_SOF;
      endcase
   end

   // Position counters and the line-0 reference length.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         x_cnt   <= '0;
         y_cnt   <= '0;
         ref_len <= '0;
      end else if (sof_strobe) begin
         x_cnt   <= line_sync_i ? C_ONE : '0;
         y_cnt   <= '0;
         ref_len <= '0;
      end else if (eof_strobe) begin
         x_cnt <= '0;
         y_cnt <= '0;
         if (line_close && (y_cnt == '0)) ref_len <= close_len;
      end else if (in_frame) begin
         if (line_sync_i) begin
            x_cnt <= sat_inc(x_cnt);
         end else if (line_close) begin
            x_cnt <= '0;
            y_cnt <= sat_inc(y_cnt);
            if (y_cnt == '0) ref_len <= close_len;
         end
      end
   end

   // Geometry of the last completed frame, captured on the EOF edge.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         frame_width    <= '0;
         frame_height   <= '0;
         geometry_valid <= 1'b0;
      end else if (eof_strobe) begin
         frame_width    <= (line_close && (y_cnt == '0)) ? close_len : ref_len;
         frame_height   <= line_open ? sat_inc(y_cnt) : y_cnt;
         geometry_valid <= 1'b1;
      end
   end

   // Sticky length error; a new mismatch beats a simultaneous clear.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) line_len_err <= 1'b0;
      else          line_len_err <= (line_len_err & ~clear_err_i) | len_mismatch;
   end

endmodule

// File: rtl/yuv_stream_cropper.sv
// Crops a word/line window out of the YUV422 stream and emits registered,
// valid-qualified words with SOF/EOL/EOF markers plus geometry/error status.
module yuv_stream_cropper
   import csi_video_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int COORD_WIDTH = COORD_WIDTH_DEF
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   frame_sync_i,
   input  logic                   line_sync_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   input  logic                   enable_i,
   input  logic [COORD_WIDTH-1:0] crop_x_start_i,
   input  logic [COORD_WIDTH-1:0] crop_x_len_i,
   input  logic [COORD_WIDTH-1:0] crop_y_start_i,
   input  logic [COORD_WIDTH-1:0] crop_y_len_i,
   input  logic                   clear_err_i,
   output logic [DATA_WIDTH-1:0]  data_o,
   output logic                   valid_o,
   output logic                   sof_o,
   output logic                   eol_o,
   output logic                   eof_o,
   output logic [COORD_WIDTH-1:0] frame_width_o,
   output logic [COORD_WIDTH-1:0] frame_height_o,
   output logic                   geometry_valid_o,
   output logic                   line_len_err_o,
   output logic                   frame_trunc_o
);

   localparam int                     EW    = COORD_WIDTH + 1;
   localparam logic [EW-1:0]          E_ONE = EW'(1);
   localparam logic [COORD_WIDTH-1:0] C_MAX = '1;

   logic                   word_valid, sof_strobe, eof_strobe;
   logic [COORD_WIDTH-1:0] x, y;

   logic                   sh_en;
   logic [COORD_WIDTH-1:0] sh_xs, sh_xl, sh_ys, sh_yl;
   logic                   eff_en;
   logic [COORD_WIDTH-1:0] eff_xs, eff_xl, eff_ys, eff_yl;
   logic [EW-1:0]          x_last, y_last;
   logic                   armed, in_x, in_y, keep;
   logic                   sof_n, eol_n, eof_n, trunc_n;
   logic                   first_done, eof_emitted;

   video_timing_counter #(.COORD_WIDTH(COORD_WIDTH)) u_timing (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .frame_sync_i   (frame_sync_i),
      .line_sync_i    (line_sync_i),
      .clear_err_i    (clear_err_i),
      .word_valid     (word_valid),
      .sof_strobe     (sof_strobe),
      .eof_strobe     (eof_strobe),
      .x              (x),
      .y              (y),
      .frame_width    (frame_width_o),
      .frame_height   (frame_height_o),
      .geometry_valid (geometry_valid_o),
      .line_len_err   (line_len_err_o)
   );

   // On the SOF cycle the live ports apply directly; afterwards the shadow does.
   assign eff_en = sof_strobe ? enable_i       : sh_en;
   assign eff_xs = sof_strobe ? crop_x_start_i : sh_xs;
   assign eff_xl = sof_strobe ? crop_x_len_i   : sh_xl;
   assign eff_ys = sof_strobe ? crop_y_start_i : sh_ys;
   assign eff_yl = sof_strobe ? crop_y_len_i   : sh_yl;

   // Window end computed one bit wider so start+len never wraps.
   assign x_last = {1'b0, eff_xs} + {1'b0, eff_xl} - E_ONE;
   assign y_last = {1'b0, eff_ys} + {1'b0, eff_yl} - E_ONE;
   assign armed  = eff_en & (eff_xl != '0) & (eff_yl != '0);
   assign in_x   = (x >= eff_xs) & ({1'b0, x} <= x_last);
   assign in_y   = (y >= eff_ys) & ({1'b0, y} <= y_last);
   assign keep   = word_valid & armed & (x != C_MAX) & (y != C_MAX) & in_x & in_y;

   assign sof_n   = keep & (sof_strobe | ~first_done);
   assign eol_n   = keep & ({1'b0, x} == x_last);
   assign eof_n   = eol_n & ({1'b0, y} == y_last);
   assign trunc_n = eof_strobe & armed & ~(eof_emitted | eof_n);

   // Window configuration captured at frame start; mid-frame changes wait.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         sh_en <= 1'b0;
         sh_xs <= '0;
         sh_xl <= '0;
         sh_ys <= '0;
         sh_yl <= '0;
      end else if (sof_strobe) begin
         sh_en <= enable_i;
         sh_xs <= crop_x_start_i;
         sh_xl <= crop_x_len_i;
         sh_ys <= crop_y_start_i;
         sh_yl <= crop_y_len_i;
      end
   end

   // Per-frame progress: first kept word seen, window end emitted.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         first_done  <= 1'b0;
         eof_emitted <= 1'b0;
      end else if (sof_strobe) begin
         first_done  <= keep;
         eof_emitted <= eof_n;
      end else begin
         first_done  <= first_done | keep;
         eof_emitted <= eof_emitted | eof_n;
      end
   end

   // Output register stage: one cycle of latency, order preserved.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         data_o        <= '0;
         valid_o       <= 1'b0;
         sof_o         <= 1'b0;
         eol_o         <= 1'b0;
         eof_o         <= 1'b0;
         frame_trunc_o <= 1'b0;
      end else begin
         if (keep) data_o <= data_i;
         valid_o       <= keep;
         sof_o         <= sof_n;
         eol_o         <= eol_n;
         eof_o         <= eof_n;
         frame_trunc_o <= trunc_n;
      end
   end

endmodule

// File: tb/tb_yuv_stream_cropper.sv
// Directed bench for yuv_stream_cropper: frames are built word by word with
// data = {line, word}, outputs are collected after every edge and compared
// against hand-computed window results.
module tb_yuv_stream_cropper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_sync = 1'b0;
   logic        line_sync = 1'b0;
   logic [31:0] data = '0;
   logic        enable = 1'b0;
   logic [11:0] crop_x_start = '0, crop_x_len = '0, crop_y_start = '0, crop_y_len = '0;
   logic        clear_err = 1'b0;
   logic [31:0] data_o;
   logic        valid_o, sof_o, eol_o, eof_o;
   logic [11:0] frame_width_o, frame_height_o;
   logic        geometry_valid_o, line_len_err_o, frame_trunc_o;

   yuv_stream_cropper dut (
      .clk_i            (clk),
      .reset_i          (rst_n),
      .frame_sync_i     (frame_sync),
      .line_sync_i      (line_sync),
      .data_i           (data),
      .enable_i         (enable),
      .crop_x_start_i   (crop_x_start),
      .crop_x_len_i     (crop_x_len),
      .crop_y_start_i   (crop_y_start),
      .crop_y_len_i     (crop_y_len),
      .clear_err_i      (clear_err),
      .data_o           (data_o),
      .valid_o          (valid_o),
      .sof_o            (sof_o),
      .eol_o            (eol_o),
      .eof_o            (eof_o),
      .frame_width_o    (frame_width_o),
      .frame_height_o   (frame_height_o),
      .geometry_valid_o (geometry_valid_o),
      .line_len_err_o   (line_len_err_o),
      .frame_trunc_o    (frame_trunc_o)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_pass = 0;
   int          n_valid, n_sof, n_eol, n_eof, n_trunc;
   logic [31:0] sof_word, eof_word;
   logic [31:0] got_q[$];

   logic        chg_en;
   logic [11:0] chg_xs, chg_xl, chg_ys, chg_yl;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic clear_stats();
      n_valid = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_trunc = 0;
      sof_word = '0; eof_word = '0;
      got_q.delete();
   endtask

   task automatic sample();
      if (valid_o) begin
         n_valid++;
         got_q.push_back(data_o);
         if (sof_o) begin n_sof++; sof_word = data_o; end
         if (eol_o) n_eol++;
         if (eof_o) begin n_eof++; eof_word = data_o; end
      end
      if (frame_trunc_o) n_trunc++;
   endtask

   task automatic step(input logic fs, input logic ls, input logic [31:0] d);
      frame_sync = fs;
      line_sync  = ls;
      data       = d;
      @(posedge clk);
      #1;
      sample();
   endtask

   task automatic set_cfg(input logic en, input logic [11:0] xs, input logic [11:0] xl,
                          input logic [11:0] ys, input logic [11:0] yl);
      enable = en; crop_x_start = xs; crop_x_len = xl; crop_y_start = ys; crop_y_len = yl;
   endtask

   // One frame: SOF in a gap, lines of nwords (short_line one word shorter), two gap
   // cycles per line, then EOF. end_open drops frame_sync on the last word itself.
   task automatic run_frame(input int nlines, input int nwords, input int short_line,
                            input int clr_line, input int chg_line, input bit end_open);
      clear_stats();
      step(1'b1, 1'b0, 32'd0);
      for (int l = 0; l < nlines; l++) begin
         int  w;
         bit  last_line;
         w = (l == short_line) ? nwords - 1 : nwords;
         last_line = end_open && (l == nlines - 1);
         if (l == chg_line) set_cfg(chg_en, chg_xs, chg_xl, chg_ys, chg_yl);
         for (int i = 0; i < w; i++)
            step((last_line && i == w - 1) ? 1'b0 : 1'b1, 1'b1, {16'(l), 16'(i)});
         if (!last_line) begin
            clear_err = (l == clr_line);
            step(1'b1, 1'b0, 32'd0);
            clear_err = 1'b0;
            if (short_line >= 0 && l == short_line - 1) chk("err_before_short", 32'(line_len_err_o), 0);
            if (short_line >= 0 && l == short_line)     chk("err_at_short_end", 32'(line_len_err_o), 1);
            step(1'b1, 1'b0, 32'd0);
         end
      end
      if (!end_open) step(1'b0, 1'b0, 32'd0);
      repeat (3) step(1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      clear_stats();
      #2;
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_data", data_o, 0);
      chk("rst_geom_valid", 32'(geometry_valid_o), 0);
      chk("rst_width", 32'(frame_width_o), 0);
      chk("rst_err", 32'(line_len_err_o), 0);
      chk("rst_trunc", 32'(frame_trunc_o), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) step(1'b0, 1'b0, 32'd0);

      // Basic window: lines 1-3, words 2-5.
      set_cfg(1'b1, 12'd2, 12'd4, 12'd1, 12'd3);
      run_frame(8, 16, -1, -1, -1, 1'b0);
      chk("t1_n_valid", n_valid, 12);
      for (int i = 0; i < got_q.size(); i++)
         chk("t1_order", got_q[i], {16'(1 + i / 4), 16'(2 + i % 4)});
      chk("t1_n_sof", n_sof, 1);
      chk("t1_sof_word", sof_word, {16'd1, 16'd2});
      chk("t1_n_eol", n_eol, 3);
      chk("t1_n_eof", n_eof, 1);
      chk("t1_eof_word", eof_word, {16'd3, 16'd5});
      chk("t1_width", 32'(frame_width_o), 16);
      chk("t1_height", 32'(frame_height_o), 8);
      chk("t1_geom_valid", 32'(geometry_valid_o), 1);
      chk("t1_trunc", n_trunc, 0);
      chk("t1_err", 32'(line_len_err_o), 0);

      // Window running past the line end.
      set_cfg(1'b1, 12'd12, 12'd8, 12'd0, 12'd2);
      run_frame(8, 16, -1, -1, -1, 1'b0);
      chk("t2_n_valid", n_valid, 8);
      chk("t2_n_eol", n_eol, 0);
      chk("t2_n_eof", n_eof, 0);
      chk("t2_trunc_cycles", n_trunc, 1);

      // Short line 4; then clear; then clear colliding with a new error.
      set_cfg(1'b1, 12'd2, 12'd4, 12'd1, 12'd3);
      run_frame(8, 16, 4, -1, -1, 1'b0);
      chk("t3_err_hold", 32'(line_len_err_o), 1);
      chk("t3_n_valid", n_valid, 12);
      chk("t3_trunc", n_trunc, 0);
      clear_err = 1'b1;
      step(1'b0, 1'b0, 32'd0);
      clear_err = 1'b0;
      chk("t3_err_cleared", 32'(line_len_err_o), 0);
      run_frame(8, 16, 4, 4, -1, 1'b0);
      chk("t3_err_after_collision", 32'(line_len_err_o), 1);
      clear_err = 1'b1;
      step(1'b0, 1'b0, 32'd0);
      clear_err = 1'b0;
      chk("t3_err_cleared2", 32'(line_len_err_o), 0);

      // Mid-frame window change only affects the next frame.
      chg_en = 1'b1; chg_xs = 12'd0; chg_xl = 12'd2; chg_ys = 12'd0; chg_yl = 12'd1;
      set_cfg(1'b1, 12'd2, 12'd4, 12'd1, 12'd3);
      run_frame(8, 16, -1, -1, 2, 1'b0);
      chk("t4_n_valid", n_valid, 12);
      chk("t4_sof_word", sof_word, {16'd1, 16'd2});
      chk("t4_eof_word", eof_word, {16'd3, 16'd5});
      run_frame(8, 16, -1, -1, -1, 1'b0);
      chk("t4_next_n_valid", n_valid, 2);
      chk("t4_next_sof_word", sof_word, {16'd0, 16'd0});
      chk("t4_next_eof_word", eof_word, {16'd0, 16'd1});
      chk("t4_next_n_eol", n_eol, 1);

      // Zero-length window and disabled output.
      set_cfg(1'b1, 12'd2, 12'd0, 12'd1, 12'd3);
      run_frame(5, 10, -1, -1, -1, 1'b0);
      chk("t5a_n_valid", n_valid, 0);
      chk("t5a_trunc", n_trunc, 0);
      chk("t5a_width", 32'(frame_width_o), 10);
      chk("t5a_height", 32'(frame_height_o), 5);
      chg_en = 1'b1; chg_xs = 12'd0; chg_xl = 12'd4; chg_ys = 12'd0; chg_yl = 12'd2;
      set_cfg(1'b0, 12'd0, 12'd4, 12'd0, 12'd2);
      run_frame(4, 8, -1, -1, 1, 1'b0);
      chk("t5b_n_valid", n_valid, 0);
      chk("t5b_trunc", n_trunc, 0);
      chk("t5b_width", 32'(frame_width_o), 8);
      chk("t5b_height", 32'(frame_height_o), 4);

      // Frame ends on the last window word itself.
      set_cfg(1'b1, 12'd0, 12'd4, 12'd2, 12'd1);
      run_frame(3, 4, -1, -1, -1, 1'b1);
      chk("t7_n_valid", n_valid, 4);
      chk("t7_n_eof", n_eof, 1);
      chk("t7_eof_word", eof_word, {16'd2, 16'd3});
      chk("t7_trunc", n_trunc, 0);
      chk("t7_height", 32'(frame_height_o), 3);
      chk("t7_width", 32'(frame_width_o), 4);
      chk("t7_err", 32'(line_len_err_o), 0);

      // Asynchronous reset mid-line, release while frame_sync is high.
      set_cfg(1'b1, 12'd0, 12'd16, 12'd0, 12'd8);
      step(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, {16'd0, 16'(i)});
      chk("t6_pre_rst_valid", 32'(valid_o), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(valid_o), 0);
      chk("t6_rst_data", data_o, 0);
      chk("t6_rst_sof", 32'(sof_o), 0);
      chk("t6_rst_geom_valid", 32'(geometry_valid_o), 0);
      chk("t6_rst_height", 32'(frame_height_o), 0);
      for (int i = 3; i < 6; i++) step(1'b1, 1'b1, {16'd0, 16'(i)});
      rst_n = 1'b1;
      clear_stats();
      for (int i = 6; i < 12; i++) step(1'b1, 1'b1, {16'd0, 16'(i)});
      step(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {16'd1, 16'(i)});
      step(1'b0, 1'b0, 32'd0);
      repeat (2) step(1'b0, 1'b0, 32'd0);
      chk("t6_no_output_after_release", n_valid, 0);
      chk("t6_no_geom_after_release", 32'(geometry_valid_o), 0);
      set_cfg(1'b1, 12'd0, 12'd4, 12'd0, 12'd2);
      run_frame(2, 4, -1, -1, -1, 1'b0);
      chk("t6_next_n_valid", n_valid, 8);
      chk("t6_next_sof_word", sof_word, {16'd0, 16'd0});
      chk("t6_next_eof_word", eof_word, {16'd1, 16'd3});
      chk("t6_next_geom_valid", 32'(geometry_valid_o), 1);
      chk("t6_next_height", 32'(frame_height_o), 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
